icache_ctrl: RTL and testbench
==============================

# icache_ctrl

Blocking instruction-cache controller that sits directly upstream of the 32-line direct-mapped cache memory. It splits the fetch address into index and tag, drives the cache-memory read port, and on a miss issues one LOAD to main memory. It matches the tagged memory response and writes the returned 64-bit line into the cache memory's write port. It also returns hit data (or bypassed fill data) to fetch.

## Interface
- MEM_TAG_W, 4, width of memory transaction tag; value 0 means "request not accepted / no response"
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state when 0
- proc2Icache_valid  in  1  fetch request present this cycle
- proc2Icache_addr  in  64  fetch byte address; bits [2:0] offset, [7:3] index, [15:8] tag, rest ignored
- Icache_valid_out  out  1  Icache_data_out holds the line for proc2Icache_addr
- Icache_data_out  out  64  instruction line
- Icache2mem_command  out  2  NONE=0, LOAD=1
- Icache2mem_addr  out  64  {48'b0, tag, index, 3'b0} of the missing line
- mem2Icache_response  in  MEM_TAG_W  non-zero = LOAD accepted with this tag
- mem2Icache_tag  in  MEM_TAG_W  tag of data returning this cycle (0 = none)
- mem2Icache_data  in  64  returned line
- rd1_idx  out  5  cache-memory read index (= addr[7:3])
- rd1_tag  out  8  cache-memory read tag (= addr[15:8])
- rd1_data  in  64  cache-memory read data
- rd1_valid  in  1  cache-memory hit
- wr1_en  out  1  cache-memory fill strobe
- wr1_idx  out  5  fill index
- wr1_tag  out  8  fill tag
- wr1_data  out  64  fill data
- hit_count  out  32  fetch cycles that returned valid data
- miss_count  out  32  LOADs accepted by memory

## Operation
- States: IDLE (no outstanding miss), WAIT (one LOAD outstanding). Registers: state, pend_tag[MEM_TAG_W], pend_idx[5], pend_ltag[8], both counters.
- Read port always driven from proc2Icache_addr; hit = proc2Icache_valid & rd1_valid.
- IDLE: if proc2Icache_valid & !rd1_valid, drive Icache2mem_command=LOAD and the line address combinationally. If mem2Icache_response≠0 that cycle, latch response into pend_tag, latch idx/tag into pend_idx/pend_ltag, miss_count+1, and go to WAIT. Otherwise stay in IDLE and retry next cycle. Otherwise command=NONE.
- WAIT: command=NONE always.
  - When mem2Icache_tag == pend_tag (pend_tag≠0): wr1_en=1 with wr1_idx=pend_idx, wr1_tag=pend_ltag, wr1_data=mem2Icache_data, and go to IDLE.
  - Non-matching tags are ignored.
- Output: Icache_valid_out=1 if hit, or if a fill occurs this cycle and proc2Icache_valid and addr[15:3]=={pend_ltag,pend_idx}. Data is rd1_data on a hit and mem2Icache_data on a bypass.
- hit_count +1 every cycle Icache_valid_out=1. Both counters wrap modulo 2^32.
- Fetch address change during WAIT: the outstanding fill still completes into pend_idx/pend_ltag. The new address is not requested until back in IDLE; no output unless it hits.
- Response tag 0 never matches; a late memory return after reset is dropped (pend_tag cleared).

## Timing
- Reset values: state=IDLE, pend_*=0, counters=0. Icache2mem_command=NONE unless a miss is combinationally present. wr1_en=0. Icache_valid_out follows rd1_valid.
- Hit: 0-cycle latency, combinational from address.
- Miss: LOAD in cycle N (the first cycle of the miss), accepted in cycle A≥N. Data is returned in cycle D>A with a bypass-valid output in D. The cache memory is written at edge D+1 and hits from cycle D+1.
- At most one outstanding LOAD. No new LOAD in the cycle the fill lands.
- Reset asserted mid-WAIT returns immediately to IDLE. The cache memory's own valids are reset separately.

## Structure
- Shared package icache_pkg: MEM_CMD enum {NONE, LOAD, STORE}, ICACHE_STATE enum {IDLE, WAIT}, constants IDX_W=5, TAG_W=8, OFF_W=3, and address field slice positions.
- No sub-module; counters and FSM are inline. The top level instantiates icache_ctrl beside the cache memory.

## Test plan
- Reset, then valid addr 0x100 with rd1_valid=1, rd1_data=0xAA → Icache_valid_out=1, data 0xAA, command NONE, hit_count=1 after the edge.
- Miss addr 0x1238, response=3 in the same cycle → command LOAD, Icache2mem_addr=0x1238. Then state WAIT, miss_count=1, pend_idx=7, pend_ltag=0x12.
- Response=0 for 3 cycles, then 5 → LOAD held 4 cycles and miss_count increments once.
- In WAIT, tag 2 returns, then tag 3 with data 0xDEAD → first ignored. On the second: wr1_en=1, wr1_idx=7, wr1_tag=0x12, bypass valid with 0xDEAD, then IDLE.
- Address changes to 0x40 (miss) during WAIT → no LOAD until the pending fill lands. Fill writes idx 7 with no bypass valid. LOAD for 0x40 next cycle.
- Reset pulse in WAIT, then mem2Icache_tag=3 → wr1_en stays 0, state IDLE, counters 0.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and address-field constants for the instruction-cache controller.
package icache_pkg;

    localparam int IDX_W  = 5;
    localparam int TAG_W  = 8;
    localparam int OFF_W  = 3;
    localparam int LINE_W = TAG_W + IDX_W;

    // Fetch address field positions: [2:0] offset, [7:3] index, [15:8] tag
    localparam int OFF_LSB = 0;
    localparam int OFF_MSB = OFF_LSB + OFF_W - 1;
    localparam int IDX_LSB = OFF_MSB + 1;
    localparam int IDX_MSB = IDX_LSB + IDX_W - 1;
    localparam int TAG_LSB = IDX_MSB + 1;
    localparam int TAG_MSB = TAG_LSB + TAG_W - 1;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } MEM_CMD;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } ICACHE_STATE;

    // Byte address of the start of a cache line
    function automatic logic [63:0] line_addr(input logic [TAG_W-1:0] tag,
                                               input logic [IDX_W-1:0] idx);
        return {48'b0, tag, idx, {OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/icache_ctrl.sv
// Blocking direct-mapped instruction-cache controller: hit path, single
// outstanding LOAD on a miss, tagged fill into the cache memory with a
// same-cycle bypass to fetch, and hit/miss event counters.
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int MEM_TAG_W = 4
) (
    input  logic                 clock,
    input  logic                 reset,

    input  logic                 proc2Icache_valid,
    input  logic [63:0]          proc2Icache_addr,
    output logic                 Icache_valid_out,
    output logic [63:0]          Icache_data_out,

    output logic [1:0]           Icache2mem_command,
    output logic [63:0]          Icache2mem_addr,
    input  logic [MEM_TAG_W-1:0] mem2Icache_response,
    input  logic [MEM_TAG_W-1:0] mem2Icache_tag,
    input  logic [63:0]          mem2Icache_data,

    output logic [IDX_W-1:0]     rd1_idx,
    output logic [TAG_W-1:0]     rd1_tag,
    input  logic [63:0]          rd1_data,
    input  logic                 rd1_valid,

    output logic                 wr1_en,
    output logic [IDX_W-1:0]     wr1_idx,
    output logic [TAG_W-1:0]     wr1_tag,
    output logic [63:0]          wr1_data,

    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
);

    ICACHE_STATE           state_reg, state_next;
    logic [MEM_TAG_W-1:0]  pend_tag_reg, pend_tag_next;
    logic [IDX_W-1:0]      pend_idx_reg, pend_idx_next;
    logic [TAG_W-1:0]      pend_ltag_reg, pend_ltag_next;
    logic [31:0]           hit_count_reg, hit_count_next;
    logic [31:0]           miss_count_reg, miss_count_next;

    logic [IDX_W-1:0]      fetch_idx;
    logic [TAG_W-1:0]      fetch_tag;
    logic                  hit;
    logic                  miss_req;
    logic                  load_accept;
    logic                  fill;
    logic                  bypass;

    // Only the index and tag fields select a line; offset and high bits are don't-care
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, proc2Icache_addr[63:TAG_MSB+1],
                                proc2Icache_addr[OFF_MSB:OFF_LSB]};

    assign fetch_idx = proc2Icache_addr[IDX_MSB:IDX_LSB];
    assign fetch_tag = proc2Icache_addr[TAG_MSB:TAG_LSB];

    // Cache-memory read port tracks the fetch address every cycle
    assign rd1_idx = fetch_idx;
    assign rd1_tag = fetch_tag;

    assign hit         = proc2Icache_valid & rd1_valid;
    assign miss_req    = (state_reg == IDLE) & proc2Icache_valid & ~rd1_valid;
    assign load_accept = miss_req & (mem2Icache_response != '0);
    // A zero pending tag can never match, so stray returns after reset are dropped
    assign fill        = (state_reg == WAIT) & (pend_tag_reg != '0) &
                         (mem2Icache_tag == pend_tag_reg);
    assign bypass      = fill & proc2Icache_valid &
                         ({fetch_tag, fetch_idx} == {pend_ltag_reg, pend_idx_reg});

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: leave IDLE when memory accepts the LOAD, leave WAIT on the matching fill
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (load_accept) state_next = WAIT;
            WAIT:    if (fill)        state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: memory command, fill strobe and fetch response
    always_comb begin
        Icache2mem_command = NONE;
        Icache2mem_addr    = '0;
        wr1_en             = 1'b0;
        wr1_idx            = pend_idx_reg;
        wr1_tag            = pend_ltag_reg;
        wr1_data           = mem2Icache_data;
        Icache_valid_out   = hit | bypass;
        Icache_data_out    = rd1_data;
        case (state_reg)
            IDLE: begin
                if (miss_req) begin
                    Icache2mem_command = LOAD;
                    Icache2mem_addr    = line_addr(fetch_tag, fetch_idx);
                end
            end
            WAIT: begin
                wr1_en = fill;
                if (bypass && !hit) begin
                    Icache_data_out = mem2Icache_data;
                end
            end
            default: ;
        endcase
    end

    // Pending-miss bookkeeping: capture on accept, clear once the fill lands
    always_comb begin
        pend_tag_next  = pend_tag_reg;
        pend_idx_next  = pend_idx_reg;
        pend_ltag_next = pend_ltag_reg;
        if (load_accept) begin
            pend_tag_next  = mem2Icache_response;
            pend_idx_next  = fetch_idx;
            pend_ltag_next = fetch_tag;
        end else if (fill) begin
            pend_tag_next  = '0;
        end
    end

    // Event counters, wrapping modulo 2^32
    always_comb begin
        hit_count_next  = hit_count_reg  + (Icache_valid_out ? 32'd1 : 32'd0);
        miss_count_next = miss_count_reg + (load_accept      ? 32'd1 : 32'd0);
    end

    // Pending-miss and counter registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_tag_reg   <= '0;
            pend_idx_reg   <= '0;
            pend_ltag_reg  <= '0;
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            pend_tag_reg   <= pend_tag_next;
            pend_idx_reg   <= pend_idx_next;
            pend_ltag_reg  <= pend_ltag_next;
            hit_count_reg  <= hit_count_next;
            miss_count_reg <= miss_count_next;
        end
    end

    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;

endmodule

// File: tb/tb_icache_ctrl.sv
// Testbench for icache_ctrl: directed scenarios followed by randomized traffic
// checked against a transaction-level model of the miss/fill protocol.
module tb_icache_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        p_valid = 1'b0;
    logic [63:0] p_addr = '0;
    logic        rd_valid = 1'b0;
    logic [63:0] rd_data = '0;
    logic [3:0]  m_resp = '0;
    logic [3:0]  m_tag = '0;
    logic [63:0] m_data = '0;

    logic        valid_out;
    logic [63:0] data_out;
    logic [1:0]  cmd;
    logic [63:0] maddr;
    logic [4:0]  rd1_idx;
    logic [7:0]  rd1_tag;
    logic        wr_en;
    logic [4:0]  wr_idx;
    logic [7:0]  wr_tag;
    logic [63:0] wr_data;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int n_vec = 0;
    int n_err = 0;

    icache_ctrl #(.MEM_TAG_W(4)) dut (
        .clock               (clock),
        .reset               (reset),
        .proc2Icache_valid   (p_valid),
        .proc2Icache_addr    (p_addr),
        .Icache_valid_out    (valid_out),
        .Icache_data_out     (data_out),
        .Icache2mem_command  (cmd),
        .Icache2mem_addr     (maddr),
        .mem2Icache_response (m_resp),
        .mem2Icache_tag      (m_tag),
        .mem2Icache_data     (m_data),
        .rd1_idx             (rd1_idx),
        .rd1_tag             (rd1_tag),
        .rd1_data            (rd_data),
        .rd1_valid           (rd_valid),
        .wr1_en              (wr_en),
        .wr1_idx             (wr_idx),
        .wr1_tag             (wr_tag),
        .wr1_data            (wr_data),
        .hit_count           (hit_count),
        .miss_count          (miss_count)
    );

    always #5 clock = ~clock;

    // Apply one cycle of inputs after the falling edge and settle combinational outputs
    task automatic drive(input logic v, input logic [63:0] a, input logic rv,
                         input logic [63:0] rd, input logic [3:0] rs,
                         input logic [3:0] mt, input logic [63:0] md);
        @(negedge clock);
        p_valid  = v;
        p_addr   = a;
        rd_valid = rv;
        rd_data  = rd;
        m_resp   = rs;
        m_tag    = mt;
        m_data   = md;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b1, 64'h100, 1'b1, 64'h77, 4'd0, 4'd3, 64'h1);
        n_vec++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL reset_valid got %0b want 1", valid_out); end
        n_vec++; if (cmd !== 2'd0) begin n_err++; $display("FAIL reset_cmd got %0d want 0", cmd); end
        n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got %0b want 0", wr_en); end
        drive(1'b0, 64'h0, 1'b0, 64'h0, 4'd0, 4'd0, 64'h0);
        reset = 1'b1;
        drive(1'b0, 64'h0, 1'b0, 64'h0, 4'd0, 4'd0, 64'h0);
        n_vec++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            n_err++; $display("FAIL reset_counters got %0d/%0d want 0/0", hit_count, miss_count); end
        $display("test_reset done");
    endtask

    task automatic test_hit();
        drive(1'b1, 64'h100, 1'b1, 64'hAA, 4'd0, 4'd0, 64'h0);
        n_vec++; if (valid_out !== 1'b1 || data_out !== 64'hAA) begin
            n_err++; $display("FAIL hit_out got %0b/%h want 1/aa", valid_out, data_out); end
        n_vec++; if (cmd !== 2'd0) begin n_err++; $display("FAIL hit_cmd got %0d want 0", cmd); end
        n_vec++; if (rd1_idx !== 5'd0 || rd1_tag !== 8'h01) begin
            n_err++; $display("FAIL hit_rdport got %h/%h want 00/01", rd1_idx, rd1_tag); end
        drive(1'b0, 64'h0, 1'b0, 64'h0, 4'd0, 4'd0, 64'h0);
        n_vec++; if (hit_count !== 32'd1) begin n_err++; $display("FAIL hit_count got %0d want 1", hit_count); end
        $display("test_hit done");
    endtask

    task automatic test_miss_fill();
        drive(1'b1, 64'h1238, 1'b0, 64'h0, 4'd3, 4'd0, 64'h0);
        n_vec++; if (cmd !== 2'd1 || maddr !== 64'h1238) begin
            n_err++; $display("FAIL miss_load got %0d/%h want 1/1238", cmd, maddr); end
        drive(1'b1, 64'h1238, 1'b0, 64'h0, 4'd0, 4'd0, 64'h0);
        n_vec++; if (cmd !== 2'd0) begin n_err++; $display("FAIL wait_cmd got %0d want 0", cmd); end
        n_vec++; if (miss_count !== 32'd1) begin n_err++; $display("FAIL miss_count got %0d want 1", miss_count); end
        n_vec++; if (dut.pend_idx_reg !== 5'd7 || dut.pend_ltag_reg !== 8'h12) begin
            n_err++; $display("FAIL pend_line got %h/%h want 07/12", dut.pend_idx_reg, dut.pend_ltag_reg); end
        drive(1'b1, 64'h1238, 1'b0, 64'h0, 4'd0, 4'd2, 64'h1111);
        n_vec++; if (wr_en !== 1'b0 || valid_out !== 1'b0) begin
            n_err++; $display("FAIL wrong_tag got wr=%0b v=%0b want 0/0", wr_en, valid_out); end
        drive(1'b1, 64'h1238, 1'b0, 64'h0, 4'd0, 4'd3, 64'hDEAD);
        n_vec++; if (wr_en !== 1'b1 || wr_idx !== 5'd7 || wr_tag !== 8'h12 || wr_data !== 64'hDEAD) begin
            n_err++; $display("FAIL fill got %0b/%h/%h/%h want 1/07/12/dead", wr_en, wr_idx, wr_tag, wr_data); end
        n_vec++; if (valid_out !== 1'b1 || data_out !== 64'hDEAD) begin
            n_err++; $display("FAIL bypass got %0b/%h want 1/dead", valid_out, data_out); end
        drive(1'b1, 64'h1238, 1'b0, 64'h0, 4'd0, 4'd0, 64'h0);
        n_vec++; if (cmd !== 2'd1 || hit_count !== 32'd2) begin
            n_err++; $display("FAIL after_fill got cmd=%0d hits=%0d want 1/2", cmd, hit_count); end
        $display("test_miss_fill done");
    endtask

    task automatic test_retry();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'h2000, 1'b0, 64'h0, (i == 3) ? 4'd5 : 4'd0, 4'd0, 64'h0);
            n_vec++; if (cmd !== 2'd1 || maddr !== 64'h2000) begin
                n_err++; $display("FAIL retry_load[%0d] got %0d/%h want 1/2000", i, cmd, maddr); end
        end
        drive(1'b0, 64'h0, 1'b0, 64'h0, 4'd0, 4'd0, 64'h0);
        n_vec++; if (miss_count !== 32'd2 || cmd !== 2'd0) begin
            n_err++; $display("FAIL retry_count got %0d cmd=%0d want 2/0", miss_count, cmd); end
        drive(1'b0, 64'h0, 1'b0, 64'h0, 4'd0, 4'd5, 64'h5);
        n_vec++; if (wr_en !== 1'b1 || wr_idx !== 5'd0 || wr_tag !== 8'h20 || valid_out !== 1'b0) begin
            n_err++; $display("FAIL retry_fill got %0b/%h/%h v=%0b want 1/00/20/0", wr_en, wr_idx, wr_tag, valid_out); end
        $display("test_retry done");
    endtask

    task automatic test_addr_change();
        drive(1'b1, 64'h1238, 1'b0, 64'h0, 4'd3, 4'd0, 64'h0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 64'h40, 1'b0, 64'h0, 4'd7, 4'd0, 64'h0);
            n_vec++; if (cmd !== 2'd0) begin n_err++; $display("FAIL change_no_load[%0d] got %0d want 0", i, cmd); end
        end
        drive(1'b1, 64'h40, 1'b0, 64'h0, 4'd0, 4'd3, 64'hBEEF);
        n_vec++; if (wr_en !== 1'b1 || wr_idx !== 5'd7 || valid_out !== 1'b0 || cmd !== 2'd0) begin
            n_err++; $display("FAIL change_fill got wr=%0b idx=%h v=%0b cmd=%0d want 1/07/0/0", wr_en, wr_idx, valid_out, cmd); end
        drive(1'b1, 64'h40, 1'b0, 64'h0, 4'd0, 4'd0, 64'h0);
        n_vec++; if (cmd !== 2'd1 || maddr !== 64'h40) begin
            n_err++; $display("FAIL change_load got %0d/%h want 1/40", cmd, maddr); end
        $display("test_addr_change done");
    endtask

    task automatic test_reset_wait();
        drive(1'b1, 64'h40, 1'b0, 64'h0, 4'd3, 4'd0, 64'h0);
        @(negedge clock);
        p_valid = 1'b0;
        m_resp  = 4'd0;
        #1 reset = 1'b0;
        #1 reset = 1'b1;
        drive(1'b0, 64'h0, 1'b0, 64'h0, 4'd0, 4'd3, 64'h55);
        n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL rstwait_wr got %0b want 0", wr_en); end
        n_vec++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            n_err++; $display("FAIL rstwait_counters got %0d/%0d want 0/0", hit_count, miss_count); end
        drive(1'b1, 64'h80, 1'b0, 64'h0, 4'd0, 4'd0, 64'h0);
        n_vec++; if (cmd !== 2'd1 || maddr !== 64'h80) begin
            n_err++; $display("FAIL rstwait_idle got %0d/%h want 1/80", cmd, maddr); end
        $display("test_reset_wait done");
    endtask

    // Randomized traffic against a transaction model: at most one pending line,
    // identified by the tag memory handed back when it took the LOAD.
    task automatic test_random();
        bit          busy = 1'b0;
        logic [3:0]  ptag = '0;
        logic [12:0] pline = '0;
        int unsigned hits = 0;
        int unsigned misses = 0;
        reset = 1'b0;
        drive(1'b0, 64'h0, 1'b0, 64'h0, 4'd0, 4'd0, 64'h0);
        reset = 1'b1;
        for (int c = 0; c < 600; c++) begin
            logic        v, rv, e_load, e_fill, e_valid;
            logic [63:0] a, rd, md, e_data;
            logic [3:0]  rs, mt;
            v  = ($urandom_range(0, 3) != 0);
            a  = {$urandom(), $urandom()};
            a[15:8] = 8'($urandom_range(0, 3));
            rv = ($urandom_range(0, 2) == 0);
            rd = {$urandom(), $urandom()};
            md = {$urandom(), $urandom()};
            rs = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            mt = (busy && $urandom_range(0, 2) == 0) ? ptag : 4'($urandom_range(0, 15));
            drive(v, a, rv, rd, rs, mt, md);
            e_load  = !busy && v && !rv;
            e_fill  = busy && mt == ptag;
            e_valid = (v && rv) || (e_fill && v && a[15:3] == pline);
            e_data  = (v && rv) ? rd : md;
            n_vec++; if (cmd !== (e_load ? 2'd1 : 2'd0) || (e_load && maddr !== {48'b0, a[15:3], 3'b0})) begin
                n_err++; $display("FAIL rnd_cmd[%0d] got %0d/%h want %0b", c, cmd, maddr, e_load); end
            n_vec++; if (wr_en !== e_fill || (e_fill && (wr_idx !== pline[4:0] || wr_tag !== pline[12:5] || wr_data !== md))) begin
                n_err++; $display("FAIL rnd_fill[%0d] got %0b/%h/%h want %0b/%h/%h", c, wr_en, wr_idx, wr_tag, e_fill, pline[4:0], pline[12:5]); end
            n_vec++; if (valid_out !== e_valid || (e_valid && data_out !== e_data)) begin
                n_err++; $display("FAIL rnd_out[%0d] got %0b/%h want %0b/%h", c, valid_out, data_out, e_valid, e_data); end
            n_vec++; if (hit_count !== hits || miss_count !== misses) begin
                n_err++; $display("FAIL rnd_counts[%0d] got %0d/%0d want %0d/%0d", c, hit_count, miss_count, hits, misses); end
            if (e_valid) hits++;
            if (e_load && rs != 0) begin
                busy = 1'b1; ptag = rs; pline = a[15:3]; misses++;
            end else if (e_fill) begin
                busy = 1'b0;
            end
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_hit();
        test_miss_fill();
        test_retry();
        test_addr_change();
        test_reset_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
